id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/rv32i_pkg.sv | 77 +++++++
 rtl/operand_forward.sv | 28 ++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, ALU function encodings and the
// decode helper used by the ID/EX pipeline register.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_sign;
        logic       b_imm;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic       funct7_5);
        dec_t d;
        d = '0;
        case (opcode)
            OPC_OP: begin
                d.alu_op    = funct3;
                d.alu_sign  = (funct3 == ALU_ADD || funct3 == ALU_SR) ? funct7_5 : 1'b0;
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                // funct7_5 is an immediate bit for addi etc.; only srai uses it
                d.alu_op    = funct3;
                d.alu_sign  = (funct3 == ALU_SR) ? funct7_5 : 1'b0;
                d.b_imm     = 1'b1;
                d.uses_rs1  = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                d.alu_op    = ALU_ADD;
                d.b_imm     = 1'b1;
                d.uses_rs1  = 1'b1;
                d.reg_write = 1'b1;
                d.mem_read  = 1'b1;
            end
            OPC_STORE: begin
                d.alu_op    = ALU_ADD;
                d.b_imm     = 1'b1;
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                d.mem_write = 1'b1;
            end
            OPC_LUI: begin
                d.alu_op    = ALU_ADD;
                d.b_imm     = 1'b1;
                d.reg_write = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/operand_forward.sv
// Priority operand select: EX/MEM result, then MEM/WB writeback, then the
// supplied register value; register 0 always yields zero.
module operand_forward #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = reg_data;
        if (addr == 5'd0) begin
            data = '0;
        end else if (ex_valid && ex_rd == addr) begin
            data = ex_data;
        end else if (wb_valid && wb_rd == addr) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU/memory controls, forwards operands
// at capture and while stalled, and stalls the decoder on load-use hazards.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            flush,
    input  logic            ex_fwd_valid,
    input  logic [4:0]      ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic            alu_sign,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            illegal
);

    dec_t            dec;
    logic            load_use;
    logic            accept;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;
    logic [XLEN-1:0] hold_rs1;
    logic [XLEN-1:0] hold_rs2;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic            b_rs2_q;

    assign dec = decode(opcode, funct3, funct7_5);

    assign load_use = out_valid && mem_read && (rd_out != 5'd0) && in_valid &&
                      ((dec.uses_rs1 && rd_out == rs1_addr) ||
                       (dec.uses_rs2 && rd_out == rs2_addr));

    assign in_ready = (!out_valid || out_ready) && !load_use && !flush && !reset;
    assign accept   = in_valid && in_ready;

    operand_forward #(.XLEN(XLEN)) u_cap_rs1 (
        .addr(rs1_addr), .reg_data(rs1_data),
        .ex_valid(ex_fwd_valid), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(cap_rs1)
    );

    operand_forward #(.XLEN(XLEN)) u_cap_rs2 (
        .addr(rs2_addr), .reg_data(rs2_data),
        .ex_valid(ex_fwd_valid), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(cap_rs2)
    );

    // Held operands fall back to their own stored value when nothing matches;
    // unused sources are stored as x0 so they stay at zero.
    operand_forward #(.XLEN(XLEN)) u_hold_rs1 (
        .addr(rs1_q), .reg_data(alu_a),
        .ex_valid(ex_fwd_valid), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(hold_rs1)
    );

    operand_forward #(.XLEN(XLEN)) u_hold_rs2 (
        .addr(rs2_q), .reg_data(store_data),
        .ex_valid(ex_fwd_valid), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(hold_rs2)
    );

    // Reset, flush and a drained slot with nothing new all collapse to a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || (!accept && out_ready)) begin
            out_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_sign   <= 1'b0;
            store_data <= '0;
            rd_out     <= '0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            illegal    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            b_rs2_q    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            alu_a      <= dec.uses_rs1 ? cap_rs1 : '0;
            alu_b      <= dec.b_imm ? imm : (dec.uses_rs2 ? cap_rs2 : '0);
            alu_op     <= dec.alu_op;
            alu_sign   <= dec.alu_sign;
            store_data <= dec.uses_rs2 ? cap_rs2 : '0;
            rd_out     <= rd_addr;
            reg_write  <= dec.reg_write;
            mem_read   <= dec.mem_read;
            mem_write  <= dec.mem_write;
            illegal    <= dec.illegal;
            rs1_q      <= dec.uses_rs1 ? rs1_addr : 5'd0;
            rs2_q      <= dec.uses_rs2 ? rs2_addr : 5'd0;
            b_rs2_q    <= dec.uses_rs2 && !dec.b_imm;
        end else if (out_valid) begin
            alu_a      <= hold_rs1;
            store_data <= hold_rs2;
            if (b_rs2_q) begin
                alu_b <= hold_rs2;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, load-use stall,
// hold refresh, flush and reset, all against hand-computed values.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic            flush;
    logic            ex_fwd_valid;
    logic [4:0]      ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            wb_fwd_valid;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a, alu_b, store_data;
    logic [2:0]      alu_op;
    logic            alu_sign;
    logic [4:0]      rd_out;
    logic            reg_write, mem_read, mem_write, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sign(alu_sign),
        .store_data(store_data), .rd_out(rd_out), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_fwd();
        ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
        wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        in_valid = 1'b1; opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
        rs1_data = d1; rs2_data = d2; imm = im;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        in_valid = 1'b0;
        clear_fwd();
        tick(); tick();
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_reg_write", reg_write, 0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);

        // sub x3, x1, x2
        tick();
        drive(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 10, 3, 0);
        tick();
        check_eq("sub_valid", out_valid, 1);
        check_eq("sub_op", alu_op, 0);
        check_eq("sub_sign", alu_sign, 1);
        check_eq("sub_a", alu_a, 10);
        check_eq("sub_b", alu_b, 3);
        check_eq("sub_rw", reg_write, 1);
        check_eq("sub_rd", rd_out, 3);
        in_valid = 1'b0;
        tick();
        check_eq("sub_drained", out_valid, 0);

        // xor with funct7_5 set: sign only meaningful for add/sub and shifts
        drive(7'b0110011, 3'b100, 1'b1, 5'd1, 5'd2, 5'd4, 1, 2, 0);
        tick();
        check_eq("xor_op", alu_op, 3'b100);
        check_eq("xor_sign", alu_sign, 0);

        // addi with funct7_5=1, then srai
        drive(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd4, 7, 99, 5);
        tick();
        check_eq("addi_sign", alu_sign, 0);
        check_eq("addi_b", alu_b, 5);
        check_eq("addi_a", alu_a, 7);
        drive(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd2, 5'd4, 7, 99, 32'h402);
        tick();
        check_eq("srai_op", alu_op, 3'b101);
        check_eq("srai_sign", alu_sign, 1);

        // forwarding priority and x0 guard
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd1; ex_fwd_data = 32'hAA;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd1; wb_fwd_data = 32'hBB;
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 0);
        tick();
        check_eq("fwd_ex_wins", alu_a, 32'hAA);
        check_eq("fwd_rs2_reg", alu_b, 32'h22);
        ex_fwd_valid = 1'b0;
        tick();
        check_eq("fwd_wb", alu_a, 32'hBB);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
        drive(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd2, 5'd5, 32'h77, 32'h22, 0);
        tick();
        check_eq("fwd_x0", alu_a, 0);
        clear_fwd();

        // store with ex-forwarded rs2
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd2; ex_fwd_data = 32'hBEEF;
        drive(7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd8, 32'h100, 32'hDEAD, 8);
        tick();
        check_eq("st_mw", mem_write, 1);
        check_eq("st_rw", reg_write, 0);
        check_eq("st_data", store_data, 32'hBEEF);
        check_eq("st_b", alu_b, 8);
        check_eq("st_a", alu_a, 32'h100);
        clear_fwd();

        // lui: a forced to zero despite nonzero rs1 field
        drive(7'b0110111, 3'b011, 1'b0, 5'd3, 5'd4, 5'd9, 32'h99, 32'h1, 32'h12345000);
        tick();
        check_eq("lui_a", alu_a, 0);
        check_eq("lui_b", alu_b, 32'h12345000);
        check_eq("lui_op", alu_op, 0);

        // illegal opcode
        drive(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd9, 1, 2, 3);
        tick();
        check_eq("ill_valid", out_valid, 1);
        check_eq("ill_flag", illegal, 1);
        check_eq("ill_rw", reg_write, 0);

        // load-use: lw x5, then add x6, x5, x7
        drive(7'b0000011, 3'b010, 1'b0, 5'd2, 5'd0, 5'd5, 32'h40, 0, 4);
        tick();
        check_eq("ld_mr", mem_read, 1);
        check_eq("ld_b", alu_b, 4);
        drive(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd7, 5'd6, 32'h1, 32'h2, 0);
        #1;
        check_eq("lu_in_ready", in_ready, 0);
        tick();
        check_eq("lu_bubble", out_valid, 0);
        check_eq("lu_bubble_mr", mem_read, 0);
        #1;
        check_eq("lu_retry_ready", in_ready, 1);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h1234;
        tick();
        check_eq("lu_issue_valid", out_valid, 1);
        check_eq("lu_issue_a", alu_a, 32'h1234);
        check_eq("lu_issue_b", alu_b, 2);
        in_valid = 1'b0;
        clear_fwd();
        tick();

        // hold with out_ready=0 while wb writes rs2 register
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd9, 5'd8, 32'h20, 32'h10, 0);
        tick();
        in_valid = 1'b0;
        check_eq("hold_cap_b", alu_b, 32'h10);
        #1;
        check_eq("hold_in_ready", in_ready, 0);
        tick();
        check_eq("hold1_b", alu_b, 32'h10);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd9; wb_fwd_data = 32'h55;
        tick();
        check_eq("hold2_b", alu_b, 32'h55);
        check_eq("hold2_sd", store_data, 32'h55);
        clear_fwd();
        tick();
        check_eq("hold3_b", alu_b, 32'h55);
        check_eq("hold3_valid", out_valid, 1);
        check_eq("hold3_a", alu_a, 32'h20);

        // flush during hold with a new instruction offered
        flush = 1'b1;
        drive(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd4, 1, 0, 1);
        #1;
        check_eq("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_rw", reg_write, 0);
        check_eq("flush_b", alu_b, 0);

        // reset mid-hold
        drive(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd4, 1, 0, 7);
        tick();
        in_valid = 1'b0;
        check_eq("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 0);
        tick();
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_b", alu_b, 0);
        check_eq("mid_rst_a", alu_a, 0);
        check_eq("mid_rst_rd", rd_out, 0);
        check_eq("mid_rst_rw", reg_write, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("after_rst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
